// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// State, size and requester encodings plus the alignment rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ERR    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = a[0];
      SZ_W:    bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the
// requester not served last wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last,
  output logic    gnt_i,
  output logic    gnt_d
);

  assign gnt_i = req_i && (!req_d || last == REQ_D);
  assign gnt_d = req_d && (!req_i || last == REQ_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter in front of one
// single-ported memory, with ack watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_size,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  req_id_t       last;
  logic [CW-1:0] cnt;
  logic          arb_i;
  logic          arb_d;
  logic          d_bad;

  rr_arb2 u_arb (
    .req_i (if_req),
    .req_d (d_req),
    .last  (last),
    .gnt_i (arb_i),
    .gnt_d (arb_d)
  );

  // grants only while idle and out of reset
  assign if_gnt = rst && (state == IDLE) && arb_i;
  assign d_gnt  = rst && (state == IDLE) && arb_d;
  assign d_bad  = misaligned(d_size, d_addr[1:0]);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= REQ_D;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_size  <= SZ_W;
            state     <= BUSY_I;
            last      <= REQ_I;
            cnt       <= '0;
          end else if (d_gnt && d_bad) begin
            d_valid <= 1'b1;
            d_err   <= 1'b1;
            last    <= REQ_D;
          end else if (d_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_size  <= d_size;
            state     <= BUSY_D;
            last      <= REQ_D;
            cnt       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // an ack on the last allowed cycle still completes
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_I) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            state   <= ERR;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter.
// Memory model returns addr ^ K after ack_lat cycles.
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int ack_lat = 0;
  int req_cycles = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] exp_d = '0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_size(d_size), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      req_cycles <= req_cycles + 1;
      if (ack_lat != 0 && req_cycles + 1 == ack_lat) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem_addr ^ K;
      end else begin
        mem_ack   <= 1'b0;
        mem_rdata <= '0;
      end
    end else begin
      req_cycles <= 0;
      mem_ack    <= 1'b0;
      mem_rdata  <= '0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    tick;
    tick;
    checks++;
    if ({mem_req, busy, timeout, if_gnt, d_gnt,
         if_valid, d_valid, d_err} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b exp 0",
        {mem_req, busy, timeout, if_gnt, d_gnt,
         if_valid, d_valid, d_err});
    end
    checks++;
    if (if_rdata !== 0 || d_rdata !== 0 || mem_addr !== 0 ||
        mem_wdata !== 0 || mem_size !== 0 || mem_we !== 0) begin
      failures++;
      $display("FAIL reset_data: if_rdata=%h d_rdata=%h addr=%h exp 0",
        if_rdata, d_rdata, mem_addr);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || if_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b if_gnt=%b exp 0", busy, if_gnt);
    end
  endtask

  task automatic test_single_fetch;
    logic [31:0] e;
    ack_lat = 3;
    if_req = 1'b1;
    if_addr = 32'h40;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      failures++;
      $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b exp 1/0", if_gnt, d_gnt);
    end
    iq.push_back(32'h40 ^ K);
    tick;
    if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 ||
          mem_size !== 2'b10 || if_valid !== 1'b0) begin
        failures++;
        $display("FAIL fetch_mem c%0d: req=%b addr=%h we=%b sz=%b exp 1/40/0/10",
          c, mem_req, mem_addr, mem_we, mem_size);
      end
      tick;
    end
    e = iq.pop_front();
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== e) begin
      failures++;
      $display("FAIL fetch_valid: valid=%b rdata=%h exp 1/%h",
        if_valid, if_rdata, e);
    end
    tick;
    checks++;
    if (if_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse: valid=%b busy=%b exp 0/0", if_valid, busy);
    end
  endtask

  task automatic test_contention;
    logic [31:0] e;
    logic want_i;
    ack_lat = 1;
    want_i = 1'b1;
    rst = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h80;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h300;
    d_size = 2'b10;
    tick;
    tick;
    rst = 1'b1;
    #1;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) begin
        if_req = 1'b0;
        d_req = 1'b0;
        #1;
      end
      checks++;
      if (if_valid !== (c == 2 || c == 6) ||
          d_valid !== (c == 4 || c == 8)) begin
        failures++;
        $display("FAIL rr_valid c%0d: if_valid=%b d_valid=%b",
          c, if_valid, d_valid);
      end
      if (if_valid === 1'b1 && iq.size() > 0) begin
        e = iq.pop_front();
        checks++;
        if (if_rdata !== e) begin
          failures++;
          $display("FAIL rr_if_rdata c%0d: got %h exp %h", c, if_rdata, e);
        end
      end
      if (d_valid === 1'b1 && dq.size() > 0) begin
        e = dq.pop_front();
        exp_d = e;
        checks++;
        if (d_rdata !== e || d_err !== 1'b0) begin
          failures++;
          $display("FAIL rr_d_rdata c%0d: got %h err=%b exp %h",
            c, d_rdata, d_err, e);
        end
      end
      checks++;
      if (c % 2 == 0 && c < 8) begin
        if (if_gnt !== want_i || d_gnt !== !want_i) begin
          failures++;
          $display("FAIL rr_gnt c%0d: if_gnt=%b d_gnt=%b exp %b/%b",
            c, if_gnt, d_gnt, want_i, !want_i);
        end
        if (want_i) iq.push_back(32'h80 ^ K);
        else dq.push_back(32'h300 ^ K);
        want_i = !want_i;
      end else if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
        failures++;
        $display("FAIL rr_nogap c%0d: if_gnt=%b d_gnt=%b exp 0/0",
          c, if_gnt, d_gnt);
      end
      tick;
    end
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      failures++;
      $display("FAIL rr_drain: pending i=%0d d=%0d exp 0/0",
        iq.size(), dq.size());
    end
  endtask

  task automatic test_misaligned;
    logic [1:0]  szs[5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
    logic [31:0] adrs[5] = '{32'h102, 32'h100, 32'h101, 32'h103, 32'h106};
    bit          bads[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] e;
    int n;
    ack_lat = 2;
    for (int i = 0; i < 5; i++) begin
      d_req = 1'b1;
      d_we = 1'b0;
      d_size = szs[i];
      d_addr = adrs[i];
      #1;
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
        failures++;
        $display("FAIL align_gnt %0d: d_gnt=%b exp 1", i, d_gnt);
      end
      if (!bads[i]) dq.push_back(adrs[i] ^ K);
      tick;
      d_req = 1'b0;
      #1;
      if (bads[i]) begin
        checks++;
        if (d_valid !== 1'b1 || d_err !== 1'b1 ||
            mem_req !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL align_rej %0d: valid=%b err=%b mem_req=%b exp 1/1/0",
            i, d_valid, d_err, mem_req);
        end
      end else begin
        n = 0;
        while (d_valid !== 1'b1 && n < 20) begin
          tick;
          n++;
        end
        e = (dq.size() > 0) ? dq.pop_front() : 32'hx;
        exp_d = e;
        checks++;
        if (d_valid !== 1'b1 || d_err !== 1'b0 || d_rdata !== e) begin
          failures++;
          $display("FAIL align_ok %0d: valid=%b err=%b rdata=%h exp 1/0/%h",
            i, d_valid, d_err, d_rdata, e);
        end
      end
      tick;
    end
  endtask

  task automatic test_store;
    int n;
    ack_lat = 2;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'hDEADBEEF;
    d_size = 2'b10;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL store_gnt: got %b exp 1", d_gnt);
    end
    tick;
    d_req = 1'b0;
    d_we = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF ||
          mem_addr !== 32'h200 || mem_size !== 2'b10) begin
        failures++;
        $display("FAIL store_mem: we=%b wdata=%h addr=%h exp 1/deadbeef/200",
          mem_we, mem_wdata, mem_addr);
      end
      tick;
      n++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL store_len: got %0d exp 2", n);
    end
    checks++;
    if (d_valid !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_d) begin
      failures++;
      $display("FAIL store_done: valid=%b err=%b rdata=%h exp 1/0/%h",
        d_valid, d_err, d_rdata, exp_d);
    end
    tick;
  endtask

  task automatic test_ack_at_limit;
    logic [31:0] e;
    int n;
    ack_lat = 16;
    if_req = 1'b1;
    if_addr = 32'h1000;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL limit_gnt: got %b exp 1", if_gnt);
    end
    iq.push_back(32'h1000 ^ K);
    tick;
    if_req = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    e = iq.pop_front();
    checks++;
    if (n != 16 || if_valid !== 1'b1 || if_rdata !== e || timeout !== 1'b0) begin
      failures++;
      $display("FAIL limit_ack: len=%0d valid=%b rdata=%h to=%b exp 16/1/%h/0",
        n, if_valid, if_rdata, timeout, e);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL limit_idle: busy=%b to=%b exp 0/0", busy, timeout);
    end
  endtask

  task automatic test_timeout;
    int n;
    ack_lat = 0;
    if_req = 1'b1;
    if_addr = 32'h2000;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL wd_gnt: got %b exp 1", if_gnt);
    end
    tick;
    if_req = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n != 16 || timeout !== 1'b1 || busy !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL wd_fire: len=%0d to=%b busy=%b valid=%b exp 16/1/1/0",
        n, timeout, busy, if_valid);
    end
    if_req = 1'b1;
    d_req = 1'b1;
    d_addr = 32'h0;
    d_size = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_req !== 1'b0 ||
          timeout !== 1'b1) begin
        failures++;
        $display("FAIL wd_sticky c%0d: gnt=%b%b req=%b to=%b exp 00/0/1",
          c, if_gnt, d_gnt, mem_req, timeout);
      end
      tick;
    end
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    int n;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ar_err_clear: to=%b busy=%b exp 0/0", timeout, busy);
    end
    tick;
    rst = 1'b1;
    tick;
    ack_lat = 0;
    if_req = 1'b1;
    if_addr = 32'h3000;
    tick;
    if_req = 1'b0;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre: req=%b busy=%b exp 1/1", mem_req, busy);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL ar_async: req=%b busy=%b to=%b exp 0/0/0",
        mem_req, busy, timeout);
    end
    if_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h400;
    d_size = 2'b10;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
        failures++;
        $display("FAIL ar_novalid c%0d: if=%b d=%b exp 0/0",
          c, if_valid, d_valid);
      end
    end
    ack_lat = 1;
    rst = 1'b1;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL ar_tie: if_gnt=%b d_gnt=%b exp 1/0", if_gnt, d_gnt);
    end
    iq.push_back(32'h3000 ^ K);
    tick;
    if_req = 1'b0;
    d_req = 1'b0;
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    e = iq.pop_front();
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== e) begin
      failures++;
      $display("FAIL ar_after: valid=%b rdata=%h exp 1/%h",
        if_valid, if_rdata, e);
    end
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_fetch;
    test_contention;
    test_misaligned;
    test_store;
    test_ack_at_limit;
    test_timeout;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the CPU's instruction-fetch requester and its load/store requester, so the core can move from split InstMem/DataMem to a unified memory.
- Uses a round-robin grant, a two-phase request/acknowledge to memory, per-requester response pulses, data-access alignment checking, and an ack watchdog.
- Error outputs feed the core's halt logic.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum BUSY cycles without mem_ack before the block errors (minimum 2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address; word access, must be word aligned
- if_gnt  out  1  fetch accepted this cycle
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DW  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- d_gnt  out  1  data request accepted this cycle
- d_valid  out  1  one-cycle completion pulse, for loads and stores
- d_rdata  out  DW  load data, raw and unextended
- d_err  out  1  pulses with d_valid when the access was rejected
- mem_req  out  1  memory request; held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_size  out  1/AW/DW/2  registered copy of the granted request
- mem_ack  in  1  memory completion; sampled only while mem_req = 1
- mem_rdata  in  DW  valid in the mem_ack cycle
- timeout  out  1  sticky; watchdog expired
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; last_served = DATA, so fetch wins the first tie.
  - All outputs are 0; rdata outputs and mem_* registers are 0.
- States: IDLE, BUSY_I, BUSY_D, ERR.
- IDLE, grant decision:
  - if_gnt and d_gnt are combinational from req and last_served. At most one is high.
  - If only one requester asserts req, it wins. If both assert, the one not equal to last_served wins.
  - Posedge after a grant:
    - latch the winner's addr, we, wdata and size into the mem_* registers (fetch forces we = 0, size = 10);
    - set mem_req = 1;
    - go to BUSY_I or BUSY_D, update last_served, clear the watchdog counter.
- Data alignment check, done in IDLE at grant:
  - The access is rejected when any of these hold: size = 11; size = 01 with addr[0] = 1; size = 10 with addr[1:0] != 0.
  - A rejected access is still granted (d_gnt = 1) but no memory access is made.
  - Next cycle: d_valid = 1, d_err = 1; state stays IDLE; last_served = DATA.
  - A misaligned fetch address is passed through unchecked; fetch alignment is the core's responsibility.
- BUSY_x:
  - mem_req stays high and the mem_* registers are stable; no grants are issued.
  - The counter increments every cycle.
  - On a posedge with mem_ack = 1: capture mem_rdata into x_rdata, pulse x_valid for the next cycle, drop mem_req, return to IDLE.
  - A grant may be issued in the same cycle x_valid is high.
  - Store completion: d_valid pulses; d_rdata is unchanged.
- Latency: req in cycle 0, gnt in cycle 0, mem_req from cycle 1, ack in cycle k ≥ 1, valid in cycle k+1.
- Watchdog:
  - Trigger: the counter reaches TIMEOUT in BUSY without mem_ack.
  - Then: go to ERR, drop mem_req, set timeout = 1. No valid pulse is issued.
  - ERR issues no grants; only reset exits it.
  - A mem_ack arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no timeout.
- mem_ack while mem_req = 0 is ignored.
- x_rdata holds its last captured value until the next completion.
- Reset mid-transaction: the transaction is abandoned; mem_req drops immediately (asynchronously); no valid pulse is issued.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, BUSY_I = 1, BUSY_D = 2, ERR = 3;
  - size encodings SZ_B, SZ_H, SZ_W;
  - requester IDs REQ_I, REQ_D.
- One natural sub-module: rr_arb2, the combinational two-way round-robin picker with a last_served input.
- Alignment check and watchdog stay inline.

Test Plan:
- Single fetch:
  - stimulus: if_req with if_addr = 0x40; memory acks 3 cycles after mem_req, mem_rdata = 0x00500093;
  - response: if_gnt in cycle 0; mem_addr = 0x40, mem_we = 0, mem_size = 10 in cycles 1–3; if_valid and if_rdata = 0x00500093 in cycle 4.
- Contention:
  - stimulus: if_req and d_req held continuously from reset, 1-cycle ack;
  - response: grants alternate I, D, I, D; the first grant is fetch; no gap cycles between completion and the next grant.
- Misaligned data access:
  - stimulus: d_req, d_size = 10, d_addr = 0x102;
  - response: d_gnt; mem_req never rises; next cycle d_valid = 1, d_err = 1.
  - Repeat with d_size = 11 and d_addr = 0x100: same response.
- Store:
  - stimulus: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_size = 10;
  - response: mem_we = 1 and mem_wdata = 0xDEADBEEF while mem_req is high; d_valid and no d_err after ack; d_rdata unchanged.
- Watchdog (TIMEOUT = 16):
  - mem_ack never asserts: mem_req drops after 16 BUSY cycles; timeout = 1, sticky; if_req is then never granted.
  - mem_ack in exactly the 16th cycle: normal completion, timeout stays 0.
- Asynchronous reset:
  - stimulus: drive rst low mid-BUSY, between clock edges;
  - response: mem_req, busy and timeout go to 0 immediately; no valid pulse; after release, the first tie is granted to fetch.
